// File: rtl/dmem_access_unit.sv
// Memory-stage load/store requester: byte-addressed LDR/STR/LDRB/STRB onto a 2^AddrW x 32
// synchronous memory with one-cycle read latency; byte stores use read-modify-write.
module dmem_access_unit #(
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic             req_byte_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  output logic             rsp_valid_o,
  output logic [31:0]      rsp_rdata_o,
  output logic             rsp_err_o,
  output logic [AddrW-1:0] mem_raddr_o,
  output logic [AddrW-1:0] mem_waddr_o,
  output logic [31:0]      mem_wdata_o,
  output logic             mem_wea_o,
  input  logic [31:0]      mem_dout_i
);

  typedef enum logic [1:0] {StIdle, StLdWait, StRmw} state_e;

  state_e           state_q;
  logic [AddrW-1:0] idx_q;
  logic [1:0]       lane_q;
  logic             byte_q;
  logic [7:0]       wbyte_q;
  logic             err_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [31:0]      rsp_rdata_q;

  logic [AddrW-1:0] req_idx;
  logic             accept;
  logic             misaligned;
  logic             word_store;
  logic [4:0]       shamt;
  logic [31:0]      ld_data;
  logic [31:0]      merged;

  assign req_idx     = req_addr_i[AddrW+1:2];
  assign req_ready_o = rst_ni & (state_q == StIdle);
  assign accept      = req_valid_i & req_ready_o;
  assign misaligned  = ~req_byte_i & (req_addr_i[1:0] != 2'b00);
  assign word_store  = req_we_i & ~req_byte_i;
  assign shamt       = {lane_q, 3'b000};

  always_comb begin
    ld_data = byte_q ? {24'b0, 8'(mem_dout_i >> shamt)} : mem_dout_i;
    merged  = (mem_dout_i & ~(32'h0000_00FF << shamt)) | (32'(wbyte_q) << shamt);
  end

  // Write port is combinational so a word store lands at the edge ending its accept cycle.
  always_comb begin
    mem_raddr_o = (state_q == StIdle) ? req_idx : idx_q;
    mem_wea_o   = (state_q == StRmw) | (accept & word_store);
    mem_waddr_o = (state_q == StRmw) ? idx_q : req_idx;
    mem_wdata_o = (state_q == StRmw) ? merged : req_wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      lane_q      <= '0;
      byte_q      <= 1'b0;
      wbyte_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= req_idx;
            lane_q  <= req_addr_i[1:0];
            byte_q  <= req_byte_i;
            wbyte_q <= req_wdata_i[7:0];
            err_q   <= misaligned;
            if (word_store) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= misaligned;
            end else if (req_we_i) begin
              state_q <= StRmw;
            end else begin
              state_q <= StLdWait;
            end
          end
        end
        StLdWait: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= ld_data;
          state_q     <= StIdle;
        end
        StRmw: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
